// File: rtl/sram_axi_responder_if.sv
// rtl/sram_axi_responder_if.sv - AXI4 slave channel bundle for sram_axi_responder
interface sram_axi_responder_if #(
   parameter int ID_WIDTH = 4
);
   logic [ID_WIDTH-1:0] S_AXI_AWID;
   logic [31:0]         S_AXI_AWADDR;
   logic [7:0]          S_AXI_AWLEN;
   logic [2:0]          S_AXI_AWSIZE;
   logic [1:0]          S_AXI_AWBURST;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;

   logic [31:0]         S_AXI_WDATA;
   logic [3:0]          S_AXI_WSTRB;
   logic                S_AXI_WLAST;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;

   logic [ID_WIDTH-1:0] S_AXI_BID;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;

   logic [ID_WIDTH-1:0] S_AXI_ARID;
   logic [31:0]         S_AXI_ARADDR;
   logic [7:0]          S_AXI_ARLEN;
   logic [2:0]          S_AXI_ARSIZE;
   logic [1:0]          S_AXI_ARBURST;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;

   logic [ID_WIDTH-1:0] S_AXI_RID;
   logic [31:0]         S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RLAST;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/sram_axi_responder.sv
// rtl/sram_axi_responder.sv - AXI4 slave serving one burst at a time from a 32-bit async SRAM
// WRAP burst support is enabled by defining SRAM_AXI_RESP_WRAP_EN.
module sram_axi_responder #(
   parameter int ID_WIDTH    = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                ACLK,
   input  logic                ARESET,
   sram_axi_responder_if.slave s_axi,
   output logic [19:0]         sram_addr,
   output logic [31:0]         sram_dq_o,
   input  logic [31:0]         sram_dq_i,
   output logic                sram_dq_oe,
   output logic                sram_ce_n,
   output logic                sram_oe_n,
   output logic                sram_we_n,
   output logic [3:0]          sram_be_n
);
`ifdef SRAM_AXI_RESP_WRAP_EN
   localparam logic LP_WRAP_EN = 1'b1;
`else
   localparam logic LP_WRAP_EN = 1'b0;
`endif
   localparam logic [2:0] LP_WAIT   = 3'(WAIT_CYCLES);
   localparam logic [1:0] LP_FIXED  = 2'b00;
   localparam logic [1:0] LP_WRAP   = 2'b10;
   localparam logic [1:0] LP_RSVD   = 2'b11;
   localparam logic [1:0] LP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_STROBE,
      S_WR_RESP,
      S_RD_STROBE,
      S_RD_RESP
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [ID_WIDTH-1:0] r_id;
   logic [19:0]         r_addr;
   logic [7:0]          r_len;
   logic [7:0]          r_beat;
   logic [1:0]          r_burst;
   logic [2:0]          r_wait;
   logic                r_burst_err;
   logic                r_last_err;
   logic                r_prefer_rd;
   logic [31:0]         r_wdata;
   logic [3:0]          r_wstrb;
   logic [31:0]         r_rdata;

   logic                w_idle;
   logic                w_aw_pick;
   logic                w_aw_hs;
   logic                w_ar_hs;
   logic [ID_WIDTH-1:0] w_req_id;
   logic [31:0]         w_req_addr;
   logic [7:0]          w_req_len;
   logic [2:0]          w_req_size;
   logic [1:0]          w_req_burst;
   logic                w_req_len_ok;
   logic                w_req_err;
   logic                w_strobe_done;
   logic                w_last_beat;
   logic [19:0]         w_wrap_mask;
   logic [19:0]         w_addr_next;
   logic                w_unused_addr_bits;

   // Round-robin between channels: a lone request always wins, a tie goes to the side not served last.
   assign w_idle    = (r_state == S_IDLE) && !ARESET;
   assign w_aw_pick = s_axi.S_AXI_AWVALID && (!s_axi.S_AXI_ARVALID || !r_prefer_rd);
   assign w_aw_hs   = w_idle && w_aw_pick;
   assign w_ar_hs   = w_idle && !w_aw_pick && s_axi.S_AXI_ARVALID;

   assign w_req_id    = w_aw_pick ? s_axi.S_AXI_AWID    : s_axi.S_AXI_ARID;
   assign w_req_addr  = w_aw_pick ? s_axi.S_AXI_AWADDR  : s_axi.S_AXI_ARADDR;
   assign w_req_len   = w_aw_pick ? s_axi.S_AXI_AWLEN   : s_axi.S_AXI_ARLEN;
   assign w_req_size  = w_aw_pick ? s_axi.S_AXI_AWSIZE  : s_axi.S_AXI_ARSIZE;
   assign w_req_burst = w_aw_pick ? s_axi.S_AXI_AWBURST : s_axi.S_AXI_ARBURST;

   assign w_req_len_ok = (w_req_len == 8'd1) || (w_req_len == 8'd3) ||
                         (w_req_len == 8'd7) || (w_req_len == 8'd15);
   assign w_req_err    = (w_req_size != 3'd2) || (w_req_burst == LP_RSVD) ||
                         ((w_req_burst == LP_WRAP) && !(LP_WRAP_EN && w_req_len_ok));

   assign w_strobe_done = (r_wait == LP_WAIT);
   assign w_last_beat   = (r_beat == r_len);
   assign w_wrap_mask   = {12'd0, r_len};

   assign w_unused_addr_bits = &{1'b0, s_axi.S_AXI_AWADDR[31:22], s_axi.S_AXI_AWADDR[1:0],
                                 s_axi.S_AXI_ARADDR[31:22], s_axi.S_AXI_ARADDR[1:0]};

   always_comb begin
      w_addr_next = r_addr + 20'd1;
      if (r_burst == LP_FIXED) begin
         w_addr_next = r_addr;
      end else if ((r_burst == LP_WRAP) && LP_WRAP_EN) begin
         w_addr_next = (r_addr & ~w_wrap_mask) | ((r_addr + 20'd1) & w_wrap_mask);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next                = r_state;
      s_axi.S_AXI_AWREADY   = w_aw_hs;
      s_axi.S_AXI_ARREADY   = w_ar_hs;
      s_axi.S_AXI_WREADY    = 1'b0;
      s_axi.S_AXI_BVALID    = 1'b0;
      s_axi.S_AXI_BID       = r_id;
      s_axi.S_AXI_BRESP     = 2'b00;
      s_axi.S_AXI_RVALID    = 1'b0;
      s_axi.S_AXI_RID       = r_id;
      s_axi.S_AXI_RDATA     = r_rdata;
      s_axi.S_AXI_RRESP     = 2'b00;
      s_axi.S_AXI_RLAST     = 1'b0;
      sram_addr             = r_addr;
      sram_dq_o             = r_wdata;
      sram_dq_oe            = 1'b0;
      sram_ce_n             = 1'b1;
      sram_oe_n             = 1'b1;
      sram_we_n             = 1'b1;
      sram_be_n             = 4'hF;
      case (r_state)
         S_IDLE: begin
            if (w_aw_hs) begin
               w_next = S_WR_DATA;
            end else if (w_ar_hs) begin
               w_next = S_RD_STROBE;
            end
         end
         S_WR_DATA: begin
            s_axi.S_AXI_WREADY = 1'b1;
            if (s_axi.S_AXI_WVALID) begin
               w_next = S_WR_STROBE;
            end
         end
         S_WR_STROBE: begin
            // Error bursts keep the beat timing but never touch the SRAM.
            if (!r_burst_err) begin
               sram_ce_n  = 1'b0;
               sram_we_n  = 1'b0;
               sram_dq_oe = 1'b1;
               sram_be_n  = ~r_wstrb;
            end
            if (w_strobe_done) begin
               w_next = w_last_beat ? S_WR_RESP : S_WR_DATA;
            end
         end
         S_WR_RESP: begin
            s_axi.S_AXI_BVALID = 1'b1;
            s_axi.S_AXI_BRESP  = (r_burst_err || r_last_err) ? LP_SLVERR : 2'b00;
            if (s_axi.S_AXI_BREADY) begin
               w_next = S_IDLE;
            end
         end
         S_RD_STROBE: begin
            if (!r_burst_err) begin
               sram_ce_n = 1'b0;
               sram_oe_n = 1'b0;
               sram_be_n = 4'h0;
            end
            if (w_strobe_done) begin
               w_next = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            s_axi.S_AXI_RVALID = 1'b1;
            s_axi.S_AXI_RRESP  = r_burst_err ? LP_SLVERR : 2'b00;
            s_axi.S_AXI_RLAST  = w_last_beat;
            if (s_axi.S_AXI_RREADY) begin
               w_next = w_last_beat ? S_IDLE : S_RD_STROBE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_id        <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_burst     <= '0;
         r_wait      <= '0;
         r_burst_err <= 1'b0;
         r_last_err  <= 1'b0;
         r_prefer_rd <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rdata     <= '0;
      end else begin
         if (w_aw_hs || w_ar_hs) begin
            r_id        <= w_req_id;
            r_addr      <= w_req_addr[21:2];
            r_len       <= w_req_len;
            r_burst     <= w_req_burst;
            r_beat      <= '0;
            r_wait      <= '0;
            r_burst_err <= w_req_err;
            r_last_err  <= 1'b0;
            r_prefer_rd <= w_aw_hs;
         end
         case (r_state)
            S_WR_DATA: begin
               if (s_axi.S_AXI_WVALID) begin
                  r_wdata <= s_axi.S_AXI_WDATA;
                  r_wstrb <= s_axi.S_AXI_WSTRB;
                  r_wait  <= '0;
                  if (s_axi.S_AXI_WLAST != w_last_beat) begin
                     r_last_err <= 1'b1;
                  end
               end
            end
            S_WR_STROBE: begin
               if (!w_strobe_done) begin
                  r_wait <= r_wait + 3'd1;
               end else if (!w_last_beat) begin
                  r_addr <= w_addr_next;
                  r_beat <= r_beat + 8'd1;
               end
            end
            S_RD_STROBE: begin
               if (!w_strobe_done) begin
                  r_wait <= r_wait + 3'd1;
               end else begin
                  r_rdata <= r_burst_err ? 32'd0 : sram_dq_i;
               end
            end
            S_RD_RESP: begin
               if (s_axi.S_AXI_RREADY && !w_last_beat) begin
                  r_addr <= w_addr_next;
                  r_beat <= r_beat + 8'd1;
                  r_wait <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_axi_responder.sv
// tb/tb_sram_axi_responder.sv - directed self-checking bench for sram_axi_responder
module tb_sram_axi_responder;
   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [19:0] sram_addr;
   logic [31:0] sram_dq_o;
   logic [31:0] sram_dq_i;
   logic        sram_dq_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 ACLK = ~ACLK;

   sram_axi_responder_if #(.ID_WIDTH(4)) axi ();

   sram_axi_responder #(.ID_WIDTH(4), .WAIT_CYCLES(1)) dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .s_axi      (axi),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_i  (sram_dq_i),
      .sram_dq_oe (sram_dq_oe),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sram_be_n  (sram_be_n)
   );

   // Behavioural SRAM: byte-enabled synchronous-looking write, combinational read.
   logic [31:0] mem [64];
   logic        mem_init;
   int          ce_cnt = 0;

   always @(posedge ACLK) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hDEAD_0000 + i;
         mem[4] <= 32'h1122_3344;
      end else if (!sram_ce_n && !sram_we_n) begin
         for (int b = 0; b < 4; b++)
            if (!sram_be_n[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
      end
   end

   always @(posedge ACLK) if (!sram_ce_n) ce_cnt <= ce_cnt + 1;

   assign sram_dq_i = mem[sram_addr[5:0]];

   logic [31:0] wdat [16];
   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [1:0]  rd_resp [16];
   logic [3:0]  rd_id [16];
   int          rd_lat0;
   logic        st_ok, oe_ok;
   logic [3:0]  be_seen;
   logic        we_seen, dqoe_seen;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   int          blat;
   int          ce0;

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tmo(input string tag);
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed timeout expected handshake", tag);
   endtask

   task automatic aw_set(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
      axi.S_AXI_AWADDR  = a;
      axi.S_AXI_AWLEN   = len;
      axi.S_AXI_AWBURST = burst;
      axi.S_AXI_AWSIZE  = size;
      axi.S_AXI_AWID    = id;
      axi.S_AXI_AWVALID = 1'b1;
   endtask

   task automatic ar_set(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
      axi.S_AXI_ARADDR  = a;
      axi.S_AXI_ARLEN   = len;
      axi.S_AXI_ARBURST = burst;
      axi.S_AXI_ARSIZE  = size;
      axi.S_AXI_ARID    = id;
      axi.S_AXI_ARVALID = 1'b1;
   endtask

   task automatic aw_wait();
      int c = 0;
      #1;
      while (!axi.S_AXI_AWREADY && c < 40) begin step(); c++; end
      if (c >= 40) tmo("aw_wait");
      step();
      axi.S_AXI_AWVALID = 1'b0;
   endtask

   task automatic ar_wait();
      int c = 0;
      #1;
      while (!axi.S_AXI_ARREADY && c < 40) begin step(); c++; end
      if (c >= 40) tmo("ar_wait");
      step();
      axi.S_AXI_ARVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
      int c = 0;
      axi.S_AXI_WDATA  = d;
      axi.S_AXI_WSTRB  = strb;
      axi.S_AXI_WLAST  = last;
      axi.S_AXI_WVALID = 1'b1;
      #1;
      while (!axi.S_AXI_WREADY && c < 40) begin step(); c++; end
      if (c >= 40) tmo("w_wait");
      step();
      axi.S_AXI_WVALID = 1'b0;
      axi.S_AXI_WLAST  = 1'b0;
      be_seen   = sram_be_n;
      we_seen   = sram_we_n;
      dqoe_seen = sram_dq_oe;
   endtask

   task automatic wr_beats(input int len, input logic [3:0] strb, input int bad);
      for (int i = 0; i <= len; i++) w_beat(wdat[i], strb, (i == len) != (i == bad));
   endtask

   task automatic b_wait();
      axi.S_AXI_BREADY = 1'b1;
      blat = 1;
      while (!axi.S_AXI_BVALID && blat < 40) begin step(); blat++; end
      if (blat >= 40) tmo("b_wait");
      bresp = axi.S_AXI_BRESP;
      bid   = axi.S_AXI_BID;
      step();
      axi.S_AXI_BREADY = 1'b0;
   endtask

   task automatic r_beat(input int stall, output logic [31:0] d, output logic last,
                         output logic [1:0] resp, output logic [3:0] id, output int lat,
                         output logic ok_st, output logic ok_oe);
      lat = 1;
      while (!axi.S_AXI_RVALID && lat < 40) begin step(); lat++; end
      if (lat >= 40) tmo("r_wait");
      d     = axi.S_AXI_RDATA;
      last  = axi.S_AXI_RLAST;
      resp  = axi.S_AXI_RRESP;
      id    = axi.S_AXI_RID;
      ok_st = 1'b1;
      ok_oe = 1'b1;
      for (int k = 0; k < stall; k++) begin
         step();
         ok_st = ok_st && (axi.S_AXI_RVALID === 1'b1) && (axi.S_AXI_RDATA === d) &&
                 (axi.S_AXI_RLAST === last) && (axi.S_AXI_RRESP === resp);
         ok_oe = ok_oe && (sram_oe_n === 1'b1);
      end
      axi.S_AXI_RREADY = 1'b1;
      step();
      axi.S_AXI_RREADY = 1'b0;
   endtask

   task automatic rd_beats(input int len, input int stall_beat, input int stall_n);
      st_ok = 1'b1;
      oe_ok = 1'b1;
      for (int i = 0; i <= len; i++) begin
         int   lat;
         logic a, b;
         r_beat((i == stall_beat) ? stall_n : 0, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], lat, a, b);
         if (i == 0) rd_lat0 = lat;
         st_ok = st_ok && a;
         oe_ok = oe_ok && b;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1;
      mem_init = 1'b1;
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_AWID = '0; axi.S_AXI_AWADDR = '0;
      axi.S_AXI_AWLEN = '0; axi.S_AXI_AWSIZE = '0; axi.S_AXI_AWBURST = '0;
      axi.S_AXI_WVALID = 1'b0; axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WLAST = 1'b0;
      axi.S_AXI_BREADY = 1'b0;
      axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_ARID = '0; axi.S_AXI_ARADDR = '0;
      axi.S_AXI_ARLEN = '0; axi.S_AXI_ARSIZE = '0; axi.S_AXI_ARBURST = '0;
      axi.S_AXI_RREADY = 1'b0;
      repeat (3) step();
      ARESET = 1'b0;
      mem_init = 1'b0;
      #1;

      chk("rst_ready", {axi.S_AXI_AWREADY, axi.S_AXI_ARREADY, axi.S_AXI_WREADY}, 3'b000);
      chk("rst_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_RLAST}, 3'b000);
      chk("rst_rdata", axi.S_AXI_RDATA, 32'h0);
      chk("rst_resp", {axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 4'h0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}, 8'b1111_1110);
      chk("rst_sram_addr", sram_addr, 20'h0);

      // Tie 1: partial-strobe write wins, then the pending read
      aw_set(32'h10, 8'd0, 2'b01, 3'd2, 4'd3);
      ar_set(32'h10, 8'd0, 2'b01, 3'd2, 4'd9);
      #1;
      chk("grant1_wr", {axi.S_AXI_AWREADY, axi.S_AXI_ARREADY}, 2'b10);
      aw_wait();
      wdat[0] = 32'hAABB_CCDD;
      wr_beats(0, 4'b0011, -1);
      chk("strobe_be_n", be_seen, 4'b1100);
      chk("strobe_we_oe", {we_seen, dqoe_seen}, 2'b01);
      b_wait();
      chk("single_bresp", bresp, 2'b00);
      chk("single_bid", bid, 4'd3);
      chk("wr_latency", blat, 3);
      chk("grant2_rd", axi.S_AXI_ARREADY, 1'b1);
      ar_wait();
      rd_beats(0, -1, 0);
      chk("partial_readback", rd_data[0], 32'h1122_CCDD);
      chk("single_rlast", rd_last[0], 1'b1);
      chk("single_rid", rd_id[0], 4'd9);
      chk("rd_latency", rd_lat0, 3);

      // Tie 2: 8-beat INCR write then read
      aw_set(32'h0, 8'd7, 2'b01, 3'd2, 4'd1);
      ar_set(32'h0, 8'd7, 2'b01, 3'd2, 4'd2);
      #1;
      chk("grant3_wr", {axi.S_AXI_AWREADY, axi.S_AXI_ARREADY}, 2'b10);
      aw_wait();
      for (int i = 0; i < 8; i++) wdat[i] = i + 1;
      wr_beats(7, 4'hF, -1);
      b_wait();
      chk("burst_bresp", bresp, 2'b00);
      chk("grant4_rd", axi.S_AXI_ARREADY, 1'b1);
      ar_wait();
      rd_beats(7, -1, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("burst_rdata%0d", i), rd_data[i], i + 1);
         chk($sformatf("burst_rlast%0d", i), rd_last[i], (i == 7));
      end
      chk("burst_rresp", {rd_resp[0], rd_resp[7]}, 4'h0);

      // Backpressure on beat 2 of a 4-beat read
      ar_set(32'h0, 8'd3, 2'b01, 3'd2, 4'd4);
      ar_wait();
      rd_beats(3, 1, 5);
      for (int i = 0; i < 4; i++) chk($sformatf("stall_rdata%0d", i), rd_data[i], i + 1);
      chk("stall_rlast", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
      chk("stall_stable", st_ok, 1'b1);
      chk("stall_oe_n_high", oe_ok, 1'b1);

      // WRAP read starting at word 6
      ce0 = ce_cnt;
      ar_set(32'h18, 8'd3, 2'b10, 3'd2, 4'd6);
      ar_wait();
      rd_beats(3, -1, 0);
`ifdef SRAM_AXI_RESP_WRAP_EN
      chk("wrap_d0", rd_data[0], 32'd7);
      chk("wrap_d1", rd_data[1], 32'd8);
      chk("wrap_d2", rd_data[2], 32'd5);
      chk("wrap_d3", rd_data[3], 32'd6);
      chk("wrap_resp", {rd_resp[0], rd_resp[3]}, 4'h0);
`else
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_err_d%0d", i), rd_data[i], 32'd0);
         chk($sformatf("wrap_err_resp%0d", i), rd_resp[i], 2'b10);
      end
      chk("wrap_err_no_ce", ce_cnt - ce0, 0);
`endif
      chk("wrap_rlast", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

      // SIZE=1 write: SLVERR, no strobe, memory untouched
      ce0 = ce_cnt;
      aw_set(32'h8, 8'd1, 2'b01, 3'd1, 4'd5);
      aw_wait();
      wdat[0] = 32'hBAD0; wdat[1] = 32'hBAD1;
      wr_beats(1, 4'hF, -1);
      b_wait();
      chk("size_err_bresp", bresp, 2'b10);
      chk("size_err_bid", bid, 4'd5);
      chk("size_err_no_ce", ce_cnt - ce0, 0);
      ar_set(32'h8, 8'd0, 2'b01, 3'd2, 4'd0);
      ar_wait();
      rd_beats(0, -1, 0);
      chk("size_err_mem", rd_data[0], 32'd3);

      // WLAST early and WLAST missing
      aw_set(32'h80, 8'd1, 2'b01, 3'd2, 4'd7);
      aw_wait();
      wr_beats(1, 4'hF, 0);
      b_wait();
      chk("wlast_early_bresp", bresp, 2'b10);
      aw_set(32'h80, 8'd1, 2'b01, 3'd2, 4'd7);
      aw_wait();
      wr_beats(1, 4'hF, 1);
      b_wait();
      chk("wlast_missing_bresp", bresp, 2'b10);

      // Reserved burst type read
      ar_set(32'h0, 8'd0, 2'b11, 3'd2, 4'd8);
      ar_wait();
      rd_beats(0, -1, 0);
      chk("rsvd_rresp", rd_resp[0], 2'b10);
      chk("rsvd_rdata", rd_data[0], 32'd0);

      // Reset in the middle of beat 3 of an 8-beat write
      aw_set(32'h40, 8'd7, 2'b01, 3'd2, 4'd2);
      aw_wait();
      for (int i = 0; i < 3; i++) w_beat(32'h100 + i, 4'hF, 1'b0);
      chk("abort_pre_we", we_seen, 1'b0);
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      chk("abort_we_n", sram_we_n, 1'b1);
      chk("abort_bvalid", axi.S_AXI_BVALID, 1'b0);
      chk("abort_wready", axi.S_AXI_WREADY, 1'b0);
      aw_set(32'h40, 8'd0, 2'b01, 3'd2, 4'd4);
      aw_wait();
      wdat[0] = 32'h5A;
      wr_beats(0, 4'hF, -1);
      b_wait();
      chk("post_abort_bresp", bresp, 2'b00);
      chk("post_abort_bid", bid, 4'd4);
      ar_set(32'h40, 8'd0, 2'b01, 3'd2, 4'd1);
      ar_wait();
      rd_beats(0, -1, 0);
      chk("post_abort_readback", rd_data[0], 32'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
